// File: rtl/lif_pkg.sv
// lif_pkg: shared widths and saturating-increment helper for the LIF neuron and spike consumers
package lif_pkg;
    localparam int DEF_WINDOW_W = 8;
    localparam int DEF_COUNT_W  = 8;
    localparam int DEF_ISI_W    = 8;

    function automatic logic [31:0] sat_max(input int w);
        return 32'((64'd1 << w) - 64'd1);
    endfunction

    // Increment step (0 or 1) that keeps a counter from passing max.
    function automatic logic sat_step(input logic [31:0] value, input logic inc,
                                      input logic [31:0] max);
        return inc && (value < max);
    endfunction
endpackage

// File: rtl/spike_edge_det.sv
// spike_edge_det: rising-edge detector on a spike train, gated by enable
//   clk, rst     : clock, async active-high reset
//   ena          : gate; an edge seen while low is lost
//   spike_in     : spike train (level or pulse)
//   spike_event  : one-cycle rising-edge event
module spike_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic spike_in,
    output logic spike_event
);
    logic spike_q;

    // spike_q tracks the input even when disabled, so enabling never fabricates an edge.
    always_ff @(posedge clk or posedge rst)
        if (rst) spike_q <= 1'b0;
        else     spike_q <= spike_in;

    assign spike_event = spike_in & ~spike_q & ena;
endmodule

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: decodes a spike train into windowed spike count and last inter-spike interval
//   clk, rst               : clock, async active-high reset
//   ena                    : count enable; low freezes counters
//   spike_in               : spike train
//   window_len             : window length minus one
//   rate_out/valid/ready   : windowed count, valid/ready handshake
//   overrun                : sticky, a window result was dropped
//   isi_out/isi_valid      : last inter-spike interval, one-cycle update pulse
//   busy                   : window in progress
module spike_rate_decoder
    import lif_pkg::*;
#(
    parameter int WINDOW_W = DEF_WINDOW_W,
    parameter int COUNT_W  = DEF_COUNT_W,
    parameter int ISI_W    = DEF_ISI_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                spike_in,
    input  logic [WINDOW_W-1:0] window_len,
    output logic [COUNT_W-1:0]  rate_out,
    output logic                rate_valid,
    input  logic                rate_ready,
    output logic                overrun,
    output logic [ISI_W-1:0]    isi_out,
    output logic                isi_valid,
    output logic                busy
);
    localparam logic [31:0] CNT_MAX = sat_max(COUNT_W);
    localparam logic [31:0] ISI_MAX = sat_max(ISI_W);

    logic                spike_event;
    logic [WINDOW_W-1:0] cycle_cnt, win_l, win_eff;
    logic [COUNT_W-1:0]  spike_cnt, result;
    logic [ISI_W-1:0]    isi_cnt;
    logic                seen_first, last, transfer, accept;

    spike_edge_det u_edge (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .spike_in   (spike_in),
        .spike_event(spike_event)
    );

    // In the first window cycle win_l is not yet loaded, so compare against the live input.
    always_comb begin
        win_eff  = (cycle_cnt == '0) ? window_len : win_l;
        last     = ena && (cycle_cnt == win_eff);
        result   = spike_cnt + COUNT_W'(sat_step(32'(spike_cnt), spike_event, CNT_MAX));
        transfer = rate_valid && rate_ready;
        accept   = last && (!rate_valid || transfer);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt  <= '0;
            win_l      <= '0;
            spike_cnt  <= '0;
            isi_cnt    <= '0;
            seen_first <= 1'b0;
            rate_out   <= '0;
            rate_valid <= 1'b0;
            overrun    <= 1'b0;
            isi_out    <= '0;
            isi_valid  <= 1'b0;
        end else begin
            isi_valid <= 1'b0;
            if (ena) begin
                cycle_cnt <= last ? '0 : cycle_cnt + WINDOW_W'(1);
                spike_cnt <= last ? '0 : result;
                if (cycle_cnt == '0) win_l <= window_len;
                if (spike_event) begin
                    if (seen_first) begin
                        isi_out   <= isi_cnt;
                        isi_valid <= 1'b1;
                    end
                    isi_cnt    <= ISI_W'(1);
                    seen_first <= 1'b1;
                end else begin
                    isi_cnt <= isi_cnt + ISI_W'(sat_step(32'(isi_cnt), 1'b1, ISI_MAX));
                end
            end
            // A window result lands only if the holding register is free or being drained now.
            if (accept) begin
                rate_out   <= result;
                rate_valid <= 1'b1;
            end else if (last) begin
                overrun <= 1'b1;
            end else if (transfer) begin
                rate_valid <= 1'b0;
            end
        end
    end

    assign busy = (cycle_cnt != '0);
endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder: directed self-checking bench for spike_rate_decoder
module tb_spike_rate_decoder;
    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       spike_in;
    logic [7:0] window_len;
    logic       rate_ready;
    logic [7:0] rate_out;
    logic       rate_valid, overrun, isi_valid, busy;
    logic [7:0] isi_out;
    logic [3:0] rate_out4;
    logic       rate_valid4, overrun4, isi_valid4, busy4;
    logic [7:0] isi_out4;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spike_rate_decoder dut (
        .clk(clk), .rst(rst), .ena(ena), .spike_in(spike_in), .window_len(window_len),
        .rate_out(rate_out), .rate_valid(rate_valid), .rate_ready(rate_ready),
        .overrun(overrun), .isi_out(isi_out), .isi_valid(isi_valid), .busy(busy)
    );

    spike_rate_decoder #(.COUNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .ena(ena), .spike_in(spike_in), .window_len(window_len),
        .rate_out(rate_out4), .rate_valid(rate_valid4), .rate_ready(rate_ready),
        .overrun(overrun4), .isi_out(isi_out4), .isi_valid(isi_valid4), .busy(busy4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        spike_in = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; ena = 1'b0; spike_in = 1'b0; window_len = 8'd9; rate_ready = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("reset_rate_out", 32'(rate_out), 0);
        chk("reset_rate_valid", 32'(rate_valid), 0);
        chk("reset_overrun", 32'(overrun), 0);
        chk("reset_isi", {isi_valid, busy, isi_out}, 0);
        tick();
        rst = 1'b0;

        // Window count: spikes at cycles 0, 3, 9 of a 10-cycle window
        ena = 1'b1;
        for (int k = 0; k < 10; k++) begin
            spike_in = (k == 0 || k == 3 || k == 9);
            tick();
            if (k == 8) chk("win_valid_early", 32'(rate_valid), 0);
        end
        chk("win_rate_out", 32'(rate_out), 3);
        chk("win_rate_valid", 32'(rate_valid), 1);
        spike_in = 1'b0;
        tick();
        chk("win_valid_drop", 32'(rate_valid), 0);

        // Held level counts once
        do_reset();
        for (int k = 0; k < 10; k++) begin
            spike_in = (k < 5);
            tick();
        end
        chk("level_rate_out", 32'(rate_out), 1);
        chk("level_rate_valid", 32'(rate_valid), 1);

        // Saturation: 20 edges in a 40-cycle window
        do_reset();
        window_len = 8'd39;
        for (int k = 0; k < 40; k++) begin
            spike_in = (k % 2 == 0);
            tick();
        end
        chk("sat_rate_out4", 32'(rate_out4), 15);
        chk("sat_rate_valid4", 32'(rate_valid4), 1);
        chk("sat_rate_out8", 32'(rate_out), 20);

        // Backpressure: counts 2 then 5 with rate_ready low
        do_reset();
        window_len = 8'd9;
        rate_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            spike_in = (k == 0 || k == 2);
            tick();
        end
        chk("bp_first_out", 32'(rate_out), 2);
        chk("bp_first_overrun", 32'(overrun), 0);
        for (int k = 0; k < 10; k++) begin
            spike_in = (k % 2 == 0);
            tick();
        end
        chk("bp_hold_out", 32'(rate_out), 2);
        chk("bp_hold_valid", 32'(rate_valid), 1);
        chk("bp_overrun", 32'(overrun), 1);
        spike_in = 1'b0;
        rate_ready = 1'b1;
        tick();
        chk("bp_drain_valid", 32'(rate_valid), 0);
        chk("bp_overrun_sticky", 32'(overrun), 1);

        // ISI: events at 10 and 17, then one 300 cycles later
        do_reset();
        window_len = 8'd255;
        for (int k = 0; k < 18; k++) begin
            spike_in = (k == 10 || k == 17);
            tick();
            if (k == 10) chk("isi_first_none", 32'(isi_valid), 0);
        end
        chk("isi_valid", 32'(isi_valid), 1);
        chk("isi_out_7", 32'(isi_out), 7);
        spike_in = 1'b0;
        tick();
        chk("isi_pulse_end", 32'(isi_valid), 0);
        for (int k = 0; k < 298; k++) tick();
        spike_in = 1'b1;
        tick();
        chk("isi_sat_valid", 32'(isi_valid), 1);
        chk("isi_out_sat", 32'(isi_out), 255);
        spike_in = 1'b0;

        // Reset mid-window discards partial count
        do_reset();
        window_len = 8'd9;
        for (int k = 0; k < 5; k++) begin
            spike_in = (k == 0 || k == 2);
            tick();
        end
        chk("mid_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", {rate_out, rate_valid, overrun, isi_out, isi_valid, busy}, 0);
        spike_in = 1'b0;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        chk("mid_no_result", 32'(rate_valid), 0);
        tick();
        chk("mid_new_valid", 32'(rate_valid), 1);
        chk("mid_new_count", 32'(rate_out), 0);

        // ena low 4 cycles mid-window; edge during the gap is lost
        do_reset();
        for (int k = 0; k < 14; k++) begin
            ena = !(k >= 3 && k <= 6);
            spike_in = (k == 1) || (k >= 4 && k <= 8);
            tick();
            if (k == 12) chk("ena_not_yet", 32'(rate_valid), 0);
        end
        chk("ena_delayed_valid", 32'(rate_valid), 1);
        chk("ena_count", 32'(rate_out), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
